// File: rtl/pattern_sender_pkg.sv
// pattern_sender_pkg
//   Shared definitions for the 1-2-3 symbol link. The symbol values and the
//   state encoding live here so that the sender and the pattern detector
//   agree on the bus encoding.
//   Contents:
//     SYM_NONE/SYM_1/SYM_2/SYM_3 : 2-bit symbol values on num
//     state_t                    : sender FSM encoding (IDLE, RUN1..3, TERM)
//     DEFAULT_CW                 : default run-length count width
package pattern_sender_pkg;

    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_1    = 2'b01;
    localparam logic [1:0] SYM_2    = 2'b10;
    localparam logic [1:0] SYM_3    = 2'b11;

    localparam int DEFAULT_CW = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN1 = 3'd1,
        ST_RUN2 = 3'd2,
        ST_RUN3 = 3'd3,
        ST_TERM = 3'd4
    } state_t;

endpackage

// File: rtl/pattern_sender_run_counter.sv
// run_counter
//   Loadable CW-bit down-counter holding the number of symbols still to be
//   sent in the current phase, including the one on the bus now.
//   A load of 0 is clamped to 1 so every phase lasts at least one cycle.
//   Ports:
//     clk      in   clock
//     reset    in   synchronous active-high reset (count -> 0)
//     load     in   load load_val (clamped) this edge
//     load_val in   CW  new run length
//     last     out  count is 1: the current symbol is the phase's last
module run_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          last
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= (load_val == '0) ? ONE : load_val;
        end else if (count != '0) begin
            // Saturates at 0 so a stray decrement never wraps to 2^CW-1.
            count <= count - ONE;
        end
    end

    assign last = (count == ONE);

endmodule

// File: rtl/pattern_sender.sv
// pattern_sender
//   Frame generator for the 2-bit symbol bus. On start (sampled in IDLE) it
//   sends max(cnt1,1) x 01, max(cnt2,1) x 10, max(cnt3,1) x 11, then a single
//   00 terminator with a done pulse.
//   Handshake: start is a level request honoured only in IDLE; there is no
//   back-pressure. busy is high from the first symbol through the
//   terminator; done is high only in the terminator cycle.
//   Ports:
//     clk       in   clock
//     reset     in   synchronous active-high reset
//     start     in   frame request
//     cnt1..3   in   CW  run lengths of 01 / 10 / 11 (0 treated as 1)
//     num       out  2   registered symbol bus
//     busy      out  registered frame-in-progress flag
//     done      out  registered terminator pulse
//     dbg_state out  current FSM state
module pattern_sender
    import pattern_sender_pkg::*;
#(
    parameter int CW = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] cnt1,
    input  logic [CW-1:0] cnt2,
    input  logic [CW-1:0] cnt3,
    output logic [1:0]    num,
    output logic          busy,
    output logic          done,
    output state_t        dbg_state
);

    state_t        state;
    // cnt1 is loaded straight into the counter at frame start; only the
    // later phases need a latched copy.
    logic [CW-1:0] c2_q;
    logic [CW-1:0] c3_q;

    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_last;

    // Counter reload: the first phase at frame start, each following phase
    // on the last symbol of the previous one. TERM needs no count.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = cnt1;
        case (state)
            ST_IDLE: begin
                cnt_load     = start;
                cnt_load_val = cnt1;
            end
            ST_RUN1: begin
                cnt_load     = cnt_last;
                cnt_load_val = c2_q;
            end
            ST_RUN2: begin
                cnt_load     = cnt_last;
                cnt_load_val = c3_q;
            end
            default: begin
                cnt_load     = 1'b0;
                cnt_load_val = cnt1;
            end
        endcase
    end

    run_counter #(.CW(CW)) u_run_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .last     (cnt_last)
    );

    // Outputs are computed for the next state so they leave on registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            num   <= SYM_NONE;
            busy  <= 1'b0;
            done  <= 1'b0;
            c2_q  <= '0;
            c3_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        c2_q  <= cnt2;
                        c3_q  <= cnt3;
                        state <= ST_RUN1;
                        num   <= SYM_1;
                        busy  <= 1'b1;
                    end else begin
                        num  <= SYM_NONE;
                        busy <= 1'b0;
                    end
                end
                ST_RUN1: begin
                    if (cnt_last) begin
                        state <= ST_RUN2;
                        num   <= SYM_2;
                    end
                end
                ST_RUN2: begin
                    if (cnt_last) begin
                        state <= ST_RUN3;
                        num   <= SYM_3;
                    end
                end
                ST_RUN3: begin
                    if (cnt_last) begin
                        state <= ST_TERM;
                        num   <= SYM_NONE;
                        done  <= 1'b1;
                    end
                end
                ST_TERM: begin
                    state <= ST_IDLE;
                    num   <= SYM_NONE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    num   <= SYM_NONE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
